pes_bcd_digit_entry: RTL and testbench

//  Upstream front-end for the bcd2bin converter. Collects an ASCII byte stream
//  of up to two decimal digits, ended by a terminator. Presents the digits as
//  dig1/dig0 and drives start with the converter's start/ready/done_tick

---
 rtl/pes_bcd_digit_entry.sv | 140 ++++++++++++++
 tb/tb_pes_bcd_digit_entry.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/pes_bcd_digit_entry.sv
// pes_bcd_digit_entry: collects up to two ASCII decimal digits and a terminator,
// then hands the BCD digits to the bcd2bin converter using its
// start/ready/done_tick handshake. Bad input gives a one-cycle err_tick.
// Optional idle timeout in D1/D2 is enabled by defining DIGIT_ENTRY_TIMEOUT_EN.
module pes_bcd_digit_entry #(
  parameter logic [7:0]  TERM_CHAR      = 8'h0D,
  parameter logic [7:0]  CLR_CHAR       = 8'h1B,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       char_valid,
  input  logic [7:0] char_in,
  output logic       char_ready,
  input  logic       conv_ready,
  input  logic       conv_done,
  output logic       start,
  output logic [3:0] dig1,
  output logic [3:0] dig0,
  output logic       err_tick,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_D1,
    S_D2,
    S_REQ,
    S_RUN
  } state_t;

  // Last counter value before the timeout fires.
  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES - 1);

  state_t     state;
  logic       accept;
  logic       is_digit;
  logic [3:0] digit_val;

  assign char_ready = (state == S_IDLE) || (state == S_D1) || (state == S_D2);
  assign busy       = (state == S_REQ) || (state == S_RUN);
  assign accept     = char_valid & char_ready;
  assign is_digit   = (char_in >= 8'h30) && (char_in <= 8'h39);
  assign digit_val  = char_in[3:0];

`ifdef DIGIT_ENTRY_TIMEOUT_EN
  logic [15:0] idle_cnt;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_LIMIT;
`endif

  // Entry state machine with registered digits, start and error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      start    <= 1'b0;
      dig1     <= '0;
      dig0     <= '0;
      err_tick <= 1'b0;
`ifdef DIGIT_ENTRY_TIMEOUT_EN
      idle_cnt <= '0;
`endif
    end else begin
      err_tick <= 1'b0;
      case (state)
        S_IDLE, S_D1, S_D2: begin
          if (accept) begin
`ifdef DIGIT_ENTRY_TIMEOUT_EN
            idle_cnt <= '0;
`endif
            if (is_digit) begin
              if (state == S_IDLE) begin
                dig1  <= '0;
                dig0  <= digit_val;
                state <= S_D1;
              end else if (state == S_D1) begin
                dig1  <= dig0;
                dig0  <= digit_val;
                state <= S_D2;
              end else begin
                err_tick <= 1'b1;
                dig1     <= '0;
                dig0     <= '0;
                state    <= S_IDLE;
              end
            end else if (char_in == TERM_CHAR) begin
              if (state != S_IDLE) state <= S_REQ;
            end else if (char_in == CLR_CHAR) begin
              dig1  <= '0;
              dig0  <= '0;
              state <= S_IDLE;
            end else begin
              err_tick <= 1'b1;
              dig1     <= '0;
              dig0     <= '0;
              state    <= S_IDLE;
            end
          end
`ifdef DIGIT_ENTRY_TIMEOUT_EN
          else if (state != S_IDLE) begin
            if (idle_cnt == TIMEOUT_LIMIT) begin
              err_tick <= 1'b1;
              dig1     <= '0;
              dig0     <= '0;
              idle_cnt <= '0;
              state    <= S_IDLE;
            end else begin
              idle_cnt <= idle_cnt + 16'd1;
            end
          end else begin
            idle_cnt <= '0;
          end
`endif
        end
        S_REQ: begin
          if (conv_ready) begin
            state <= S_RUN;
            start <= 1'b1;
          end
        end
        S_RUN: begin
          if (conv_done) begin
            state <= S_IDLE;
            start <= 1'b0;
            dig1  <= '0;
            dig0  <= '0;
          end
        end
        default: begin
          state <= S_IDLE;
          start <= 1'b0;
          dig1  <= '0;
          dig0  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pes_bcd_digit_entry.sv
// Testbench for pes_bcd_digit_entry: directed scenarios plus randomized byte
// traffic, all checked every cycle against a digit-list reference model.
module tb_pes_bcd_digit_entry;

  localparam logic [7:0] TERM = 8'h0D;
  localparam logic [7:0] CLR  = 8'h1B;
  localparam int         TO   = 20;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       char_valid;
  logic [7:0] char_in;
  logic       char_ready;
  logic       conv_ready;
  logic       conv_done;
  logic       start;
  logic [3:0] dig1;
  logic [3:0] dig0;
  logic       err_tick;
  logic       busy;

  int total = 0;
  int bad   = 0;

  // Reference model: list of entered digits plus a conversion phase
  // (0 = collecting, 1 = waiting for converter ready, 2 = converting).
  int q[$];
  int phase;
  int err_exp;
  int idle;

  pes_bcd_digit_entry #(
    .TERM_CHAR(TERM),
    .CLR_CHAR(CLR),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .char_valid(char_valid),
    .char_in(char_in),
    .char_ready(char_ready),
    .conv_ready(conv_ready),
    .conv_done(conv_done),
    .start(start),
    .dig1(dig1),
    .dig0(dig0),
    .err_tick(err_tick),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_value();
    int n = 0;
    foreach (q[i]) n = n * 10 + q[i];
    return n;
  endfunction

  task automatic model_reset();
    q.delete();
    phase   = 0;
    err_exp = 0;
    idle    = 0;
  endtask

  task automatic model_update(input logic v, input logic [7:0] c, input logic cr, input logic cd);
    err_exp = 0;
    if (phase == 0) begin
      if (v) begin
        idle = 0;
        if (c >= "0" && c <= "9") begin
          if (q.size() < 2) q.push_back(int'(c) - 48);
          else begin err_exp = 1; q.delete(); end
        end else if (c == TERM) begin
          if (q.size() > 0) phase = 1;
        end else if (c == CLR) begin
          q.delete();
        end else begin
          err_exp = 1;
          q.delete();
        end
      end
`ifdef DIGIT_ENTRY_TIMEOUT_EN
      else if (q.size() > 0) begin
        idle++;
        if (idle == TO) begin
          err_exp = 1;
          q.delete();
          idle = 0;
        end
      end
`endif
    end else if (phase == 1) begin
      if (cr) phase = 2;
    end else begin
      if (cd) begin
        phase = 0;
        q.delete();
      end
    end
  endtask

  task automatic compare_all();
    int e1, e0;
    e1 = (q.size() == 2) ? q[0] : 0;
    e0 = (q.size() == 2) ? q[1] : ((q.size() == 1) ? q[0] : 0);
    check_eq("dig1", 32'(dig1), 32'(e1));
    check_eq("dig0", 32'(dig0), 32'(e0));
    check_eq("start", 32'(start), 32'(phase == 2));
    check_eq("busy", 32'(busy), 32'(phase != 0));
    check_eq("char_ready", 32'(char_ready), 32'(phase == 0));
    check_eq("err_tick", 32'(err_tick), 32'(err_exp));
    if (phase == 2) check_eq("bin", 32'(dig1) * 10 + 32'(dig0), 32'(exp_value()));
  endtask

  // One clock: drive at the falling edge, model the rising edge, check at the next falling edge.
  task automatic step(input logic v, input logic [7:0] c, input logic cr, input logic cd);
    char_valid = v;
    char_in    = c;
    conv_ready = cr;
    conv_done  = cd;
    @(posedge clk);
    model_update(v, c, cr, cd);
    @(negedge clk);
    compare_all();
  endtask

  task automatic send(input logic [7:0] c);
    step(1'b1, c, 1'b0, 1'b0);
  endtask

  initial begin
    logic [7:0] c;
    int r;
    rst_n      = 1'b0;
    char_valid = 1'b0;
    char_in    = '0;
    conv_ready = 1'b0;
    conv_done  = 1'b0;
    model_reset();
    @(negedge clk);
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    compare_all();

    // "42" + terminator, converter ready, done after a few cycles
    send("4"); send("2"); send(TERM);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check_eq("t1_start", 32'(start), 32'd1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    check_eq("t1_idle_ready", 32'(char_ready), 32'd1);

    // single digit "7"
    send("7"); send(TERM);
    check_eq("t2_dig0", 32'(dig0), 32'd7);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // third digit, bad char, clear, lone terminator
    send("1"); send("2"); send("3");
    send("5"); send("A");
    send("9"); send(CLR);
    send(TERM);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // converter not ready: byte held on char_valid must wait
    send("8"); send("8"); send(TERM);
    for (int i = 0; i < 10; i++) step(1'b1, "1", 1'b0, 1'b0);
    step(1'b1, "1", 1'b1, 1'b0);
    step(1'b1, "1", 1'b0, 1'b0);
    step(1'b1, "1", 1'b0, 1'b1);
    step(1'b1, "1", 1'b0, 1'b0);
    send(CLR);

`ifdef DIGIT_ENTRY_TIMEOUT_EN
    send("3");
    for (int i = 0; i < TO; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
    check_eq("timeout_err", 32'(err_tick), 32'd1);
`endif

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      r = int'($urandom_range(0, 15));
      if (r < 10) c = 8'(48 + r);
      else if (r < 12) c = TERM;
      else if (r == 12) c = CLR;
      else begin
        c = 8'($urandom_range(0, 255));
        if ((c >= "0" && c <= "9") || c == TERM || c == CLR) c = "A";
      end
      step($urandom_range(0, 3) != 0, c, $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0);
    end

    // reset during conversion
    send(CLR);
    send("6"); send("1"); send(TERM);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    check_eq("pre_rst_start", 32'(start), 32'd1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 8'h00, 1'b1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
